// File: rtl/console_pkg.sv
// console_pkg: shared types and framing constants for the console transmit path.
package console_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count and sticky drop flag.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             ovf_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;
    assign full     = count_q == CW'(DEPTH);
    assign empty    = count_q == '0;
    assign count    = count_q;
    assign overflow = ovf_q;
    assign dout     = mem_q[rd_ptr_q];
    assign do_pop   = pop && !empty;
    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign do_push  = push && (!full || do_pop);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
            ovf_q   <= ovf_q | (push && !do_push);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/console_tx.sv
// console_tx: buffers printed characters and serializes them as 8N1 frames on tx.
module console_tx
    import console_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   tx
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] RELOAD = TW'(CLKS_PER_BIT - 1);
    tx_state_t   state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]  idx_q;
    logic [7:0]  shift_q, head;
    logic        tx_q, busy_q, pop, timer_done;
    sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_en),
        .pop      (pop),
        .din      (wr_data),
        .dout     (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );
    assign timer_done = timer_q == '0;
    // Loading from STOP on expiry keeps back-to-back frames gapless.
    assign pop  = !empty && (state_q == IDLE || (state_q == STOP && timer_done));
    assign tx   = tx_q;
    assign busy = busy_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
            busy_q  <= 1'b0;
        end else if (pop) begin
            state_q <= START;
            shift_q <= head;
            timer_q <= RELOAD;
            tx_q    <= START_BIT;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= STOP_BIT;
                    busy_q <= 1'b0;
                end
                START: begin
                    if (timer_done) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        timer_q <= RELOAD;
                        tx_q    <= shift_q[0];
                    end else timer_q <= timer_q - 1'b1;
                end
                DATA: begin
                    if (timer_done) begin
                        timer_q <= RELOAD;
                        if (idx_q == 3'(DATA_BITS - 1)) begin
                            state_q <= STOP;
                            tx_q    <= STOP_BIT;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end else timer_q <= timer_q - 1'b1;
                end
                STOP: begin
                    if (timer_done) begin
                        state_q <= IDLE;
                        tx_q    <= STOP_BIT;
                        busy_q  <= 1'b0;
                    end else timer_q <= timer_q - 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_console_tx.sv
// tb_console_tx: directed checks of console_tx framing, FIFO limits and reset.
module tb_console_tx;
    logic       clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, busy, tx;
    logic [4:0] count;
    console_tx #(.DEPTH(16), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .busy(busy), .tx(tx)
    );
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;
    typedef struct {logic [7:0] b; logic ok; int t;} frame_t;
    frame_t     fq[$];
    int         ph = -1, last_fall = 0, busy_bad = 0;
    logic [7:0] sh;
    logic       st;
    // Frame decoder: samples mid-bit, 1 time unit after each edge.
    always begin
        frame_t f;
        @(posedge clk); #1;
        if (!rst_n) ph = -1;
        else if (ph < 0) begin
            if (!tx) begin
                ph = 0; last_fall = cyc; sh = '0;
                if (!busy) busy_bad++;
            end
        end else begin
            ph++;
            if (!busy) busy_bad++;
            if (ph % 4 == 2) begin
                if (ph == 2) st = !tx;
                else if (ph < 38) sh[ph/4-1] = tx;
                else begin
                    f.b = sh; f.ok = st && tx; f.t = last_fall;
                    fq.push_back(f);
                end
            end
            if (ph == 39) ph = -1;
        end
    end
    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk); #2;
    endtask
    task automatic wr(input logic [7:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        fq.delete();
        busy_bad = 0;
    endtask
    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (fq.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("frames", fq.size(), n);
    endtask
    initial begin
        int wc, t0;
        do_reset();
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        // single 'A'
        wr(8'h41);
        wc = cyc;
        chk("a_tx_hold", tx, 1);
        chk("a_count", count, 1);
        wait_frames(1, 100);
        if (fq.size() >= 1) begin
            chk("a_byte", fq[0].b, 8'h41);
            chk("a_frame", fq[0].ok, 1);
            chk("a_lat", fq[0].t, wc + 1);
            t0 = fq[0].t;
            while (cyc < t0 + 40) tick();
        end
        chk("a_end_tx", tx, 1);
        chk("a_end_busy", busy, 0);
        chk("a_end_empty", empty, 1);
        chk("a_busy_gap", busy_bad, 0);
        // "Hi" back-to-back
        do_reset();
        wr(8'h48);
        chk("hi_cnt0", count, 1);
        wr(8'h69);
        chk("hi_cnt1", count, 1);
        tick();
        chk("hi_cnt2", count, 1);
        wait_frames(2, 150);
        if (fq.size() >= 2) begin
            chk("hi_b0", fq[0].b, 8'h48);
            chk("hi_b1", fq[1].b, 8'h69);
            chk("hi_ok", fq[0].ok && fq[1].ok, 1);
            chk("hi_gap", fq[1].t - fq[0].t, 40);
            t0 = fq[1].t;
            while (cyc < t0 + 40) tick();
        end
        chk("hi_end_busy", busy, 0);
        chk("hi_busy_gap", busy_bad, 0);
        // overflow
        do_reset();
        wr(8'hEE);
        tick(); tick();
        for (int i = 0; i < 17; i++) begin
            wr(8'(i));
            if (i == 15) begin
                chk("ov_full16", full, 1);
                chk("ov_cnt16", count, 16);
                chk("ov_flag16", overflow, 0);
            end
        end
        chk("ov_flag", overflow, 1);
        chk("ov_cnt17", count, 16);
        wait_frames(17, 17 * 40 + 100);
        if (fq.size() >= 17) begin
            chk("ov_b0", fq[0].b, 8'hEE);
            for (int i = 0; i < 16; i++) chk($sformatf("ov_b%0d", i + 1), fq[i+1].b, i);
        end
        chk("ov_sticky", overflow, 1);
        chk("ov_empty", empty, 1);
        // push on full with simultaneous pop
        do_reset();
        wr(8'h01);
        tick(); tick();
        for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
        chk("pp_cnt16", count, 16);
        t0 = last_fall;
        while (cyc < t0 + 39) tick();
        wr(8'hAA);
        chk("pp_cnt", count, 16);
        chk("pp_ovf", overflow, 0);
        wait_frames(18, 18 * 40 + 100);
        if (fq.size() >= 18) begin
            chk("pp_first", fq[0].b, 8'h01);
            chk("pp_second", fq[1].b, 8'h10);
            chk("pp_16th", fq[16].b, 8'h1F);
            chk("pp_last", fq[17].b, 8'hAA);
        end
        chk("pp_ovf_end", overflow, 0);
        // reset mid-frame
        do_reset();
        wr(8'h55); wr(8'h01); wr(8'h02); wr(8'h03);
        chk("rm_cnt", count, 3);
        t0 = last_fall;
        while (cyc < t0 + 17) tick();
        chk("rm_bit3", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("rm_tx", tx, 1);
        chk("rm_count", count, 0);
        chk("rm_empty", empty, 1);
        chk("rm_busy", busy, 0);
        tick(); tick();
        rst_n = 1'b1;
        fq.delete();
        repeat (100) tick();
        chk("rm_noframes", fq.size(), 0);
        chk("rm_tx_idle", tx, 1);
        chk("rm_busy_idle", busy, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
